mem_addr_arbiter: RTL

//  Arbitrates the shared memory-address port among 4 requesters and drives the 3-bit

---
 rtl/mem_addr_arbiter_if.sv | 20 ++
 rtl/mem_addr_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_addr_arbiter_if.sv
// rtl/mem_addr_arbiter_if.sv - requester/arbiter bus bundle for the memory-address arbiter
interface mem_addr_arbiter_if;
  logic [3:0] req;
  logic [3:0] wr;
  logic [3:0] grant;
  logic [3:0] done;
  logic [2:0] mux_sel;
  logic       mem_wr;
  logic       busy;

  modport master (
    output req, wr,
    input  grant, done, mux_sel, mem_wr, busy
  );

  modport slave (
    input  req, wr,
    output grant, done, mux_sel, mem_wr, busy
  );
endinterface

// File: rtl/mem_addr_arbiter.sv
// rtl/mem_addr_arbiter.sv - 4-requester memory-address arbiter with wait-state counter
// MEMARB_RR_EN selects round-robin among requesters 0,1,3; otherwise fixed priority 2>1>3>0.
module mem_addr_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_addr_arbiter_if.slave bus
);

  localparam int LAT_EFF = (MEM_LAT == 0) ? 1 : MEM_LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       owner;
  logic [1:0]       win;
  logic             any_req;

  assign any_req = |bus.req;

`ifdef MEMARB_RR_EN
  logic [1:0] rr_ptr;
  logic [1:0] cand1;
  logic [1:0] cand2;

  // Cyclic order over the non-exception requesters: 0 -> 1 -> 3 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd3;
      default: rr_next = 2'd0;
    endcase
  endfunction

  assign cand1 = rr_next(rr_ptr);
  assign cand2 = rr_next(cand1);

  always_comb begin
    win = 2'd0;
    if (bus.req[2])           win = 2'd2;
    else if (bus.req[rr_ptr]) win = rr_ptr;
    else if (bus.req[cand1])  win = cand1;
    else                      win = cand2;
  end
`else
  always_comb begin
    win = 2'd0;
    if (bus.req[2])      win = 2'd2;
    else if (bus.req[1]) win = 2'd1;
    else if (bus.req[3]) win = 2'd3;
    else                 win = 2'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 2'd0;
      bus.grant   <= 4'b0000;
      bus.done    <= 4'b0000;
      bus.mux_sel <= 3'b000;
      bus.mem_wr  <= 1'b0;
      bus.busy    <= 1'b0;
`ifdef MEMARB_RR_EN
      rr_ptr      <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 4'b0000;
          if (any_req) begin
            state       <= ACCESS;
            owner       <= win;
            cnt         <= CNT_LOAD;
            bus.grant   <= 4'b0001 << win;
            bus.mux_sel <= {1'b0, win};
            bus.mem_wr  <= bus.wr[win];
            bus.busy    <= 1'b1;
          end else begin
            bus.grant   <= 4'b0000;
            bus.mux_sel <= 3'b000;
            bus.mem_wr  <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        ACCESS: begin
          // Requests are not re-examined here: a dropped req still completes.
          if (cnt == '0) begin
            state      <= DONE;
            bus.done   <= 4'b0001 << owner;
            bus.mem_wr <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.done    <= 4'b0000;
          bus.grant   <= 4'b0000;
          bus.mux_sel <= 3'b000;
          bus.mem_wr  <= 1'b0;
          bus.busy    <= 1'b0;
`ifdef MEMARB_RR_EN
          if (owner != 2'd2) rr_ptr <= rr_next(owner);
`endif
        end
        default: begin
          state       <= IDLE;
          bus.done    <= 4'b0000;
          bus.grant   <= 4'b0000;
          bus.mux_sel <= 3'b000;
          bus.mem_wr  <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
